ball_ctrl: RTL and testbench
============================

Name: ball_ctrl

Overview:
- Consumer side of the paddle position interface: takes the 9-bit paddle x coordinate and button inputs, and produces the ball position plus game state for the renderer.
- Steps the ball one pixel per axis on each `tick` (frame-rate strobe).
- Reflects the ball off the walls, the paddle and brick-hit pulses; counts lives.
- Sits between the paddle block, the brick grid and the VGA draw logic.

Parameters:
- BALL_SIZE, 8, ball edge length in pixels.
- PADDLE_W, 62, paddle width in pixels.
- PADDLE_Y, 440, top row of the paddle.
- LEFT_WALL, 134, left play-field boundary x.
- RIGHT_WALL, 506, right play-field boundary x.
- TOP_WALL, 40, top play-field boundary y.
- BOTTOM_Y, 480, miss line y.
- LIVES, 3, lives granted at reset (1..3).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-cycle strobe; ball advances only on tick
- start  in  1  serve button, active-low
- paddle_x  in  9  paddle left edge x
- brick_hit  in  1  one-cycle pulse from the brick grid; invert vertical direction
- ball_x  out  10  ball left edge x
- ball_y  out  10  ball top edge y
- dir_x  out  1  1 = moving right
- dir_y  out  1  1 = moving down
- lives  out  2  remaining lives
- miss  out  1  one-cycle pulse when the ball crosses BOTTOM_Y
- game_over  out  1  high in the OVER state

Behaviour:
- State machine SERVE, PLAY, OVER; all registers update on posedge clk.
- Reset (rst=1 at an edge, including mid-game) forces:
  - state=SERVE, lives=LIVES, dir_x=1, dir_y=0, miss=0, game_over=0.
  - ball_x=290+PADDLE_W/2-BALL_SIZE/2 (317 with defaults).
  - ball_y=PADDLE_Y-BALL_SIZE (432).
- SERVE:
  - Every clock: ball_x <= paddle_x+PADDLE_W/2-BALL_SIZE/2, ball_y <= PADDLE_Y-BALL_SIZE. This is one cycle of latency behind paddle_x.
  - tick and brick_hit are ignored.
  - start==0 sampled -> PLAY with dir_x=1, dir_y=0.
- PLAY, on a tick cycle, in this order:
  1. Direction update from the current position:
     - ball_x<=LEFT_WALL and dir_x=0 -> dir_x=1.
     - ball_x+BALL_SIZE>=RIGHT_WALL and dir_x=1 -> dir_x=0.
     - ball_y<=TOP_WALL and dir_y=0 -> dir_y=1.
     - Paddle hit: dir_y=1 and ball_y+BALL_SIZE==PADDLE_Y and ball_x+BALL_SIZE>paddle_x and ball_x<paddle_x+PADDLE_W -> dir_y=0.
     - brick_hit this cycle -> dir_y inverted. Applied after the wall/paddle rules. If brick_hit and the top-wall rule both fire, net dir_y=0.
  2. Move: ball_x +/- 1 and ball_y +/- 1 using the updated directions.
  3. Miss: if the updated ball_y+BALL_SIZE>=BOTTOM_Y:
     - pulse miss for 1 cycle; lives <= lives-1.
     - If lives was 1 -> OVER; else -> SERVE (ball re-snaps next cycle).
- PLAY, brick_hit on a non-tick cycle: dir_y inverts immediately. Position is unchanged.
- Corner case: left/right and top/paddle reflections may fire on the same tick; both axes update independently.
- OVER:
  - game_over=1; ball frozen; lives=0.
  - tick, start and brick_hit are ignored. Only rst exits.
- Arithmetic:
  - All comparisons are done at 11 bits unsigned; paddle_x is zero-extended.
  - Walls guarantee no underflow/overflow of the 10-bit ball_x/ball_y.

Optional Feature:
- Macro `BALL_CTRL_ENGLISH_EN`.
- When defined, a paddle hit also sets horizontal direction by contact point:
  - ball centre < paddle_x+PADDLE_W/3 -> dir_x=0.
  - ball centre >= paddle_x+2*PADDLE_W/3 -> dir_x=1.
  - Middle third leaves dir_x unchanged.
- When undefined, paddle hits never alter dir_x.

Decomposition:
- Shared package `brick_pkg`:
  - Playfield constants (LEFT_WALL, RIGHT_WALL, TOP_WALL, BOTTOM_Y, PADDLE_Y, PADDLE_W).
  - Game-state enum {SERVE, PLAY, OVER}.
  - Also consumed by the paddle and brick-grid blocks.
- One natural sub-module, `ball_collide`: combinational reflection logic (walls, paddle, english) returning next dir_x/dir_y. The FSM, position registers and lives counter stay in `ball_ctrl`.

Test Plan:
- Reset with paddle_x=290 -> ball_x=317, ball_y=432, lives=3, game_over=0. Then paddle_x=300 -> ball_x=327 one cycle later.
- start=0 then tick -> state PLAY, ball_x=318, ball_y=431. Ball run up to ball_y=40 with dir_y=0, next tick -> dir_y=1, ball_y=41.
- Ball at ball_x=498 (x+8=506), dir_x=1, tick -> dir_x=0, ball_x=497. Mirror case at ball_x=134 -> dir_x=1, ball_x=135.
- Paddle hit: paddle_x=300, ball_y=432, ball_x=320, dir_y=1, tick -> dir_y=0, ball_y=431. The same setup with ball_x=380 -> no bounce.
- Miss sequence: three bottom crossings -> miss pulses, lives 2,1,0, final game_over=1. Then start/tick have no effect; rst=1 restores lives=3.
- brick_hit on a non-tick cycle with dir_y=0 -> dir_y=1, position unchanged. With `BALL_CTRL_ENGLISH_EN`: hit at ball_x=300 (centre 304 < 320) -> dir_x=0.

Source files
------------

// File: rtl/brick_pkg.sv
// Playfield constants and game-state type shared by the
// paddle, brick-grid and ball blocks.
package brick_pkg;

    localparam int BALL_SIZE  = 8;
    localparam int PADDLE_W   = 62;
    localparam int PADDLE_Y   = 440;
    localparam int LEFT_WALL  = 134;
    localparam int RIGHT_WALL = 506;
    localparam int TOP_WALL   = 40;
    localparam int BOTTOM_Y   = 480;
    localparam int LIVES      = 3;

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        OVER
    } game_state_t;

endpackage

// File: rtl/ball_ctrl_if.sv
// Paddle/button inputs and ball/game-state outputs of ball_ctrl.
// master drives the inputs; slave is the ball controller.
interface ball_ctrl_if;

    logic       tick;
    logic       start;
    logic [8:0] paddle_x;
    logic       brick_hit;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic [1:0] lives;
    logic       miss;
    logic       game_over;

    modport master (
        output tick, start, paddle_x, brick_hit,
        input  ball_x, ball_y, dir_x, dir_y,
        input  lives, miss, game_over
    );

    modport slave (
        input  tick, start, paddle_x, brick_hit,
        output ball_x, ball_y, dir_x, dir_y,
        output lives, miss, game_over
    );

endinterface

// File: rtl/ball_collide.sv
// Combinational reflection: walls, paddle and brick pulse.
// Contact-point english on paddle hits with BALL_CTRL_ENGLISH_EN.
module ball_collide
#(
    parameter int BALL_SIZE  = brick_pkg::BALL_SIZE,
    parameter int PADDLE_W   = brick_pkg::PADDLE_W,
    parameter int PADDLE_Y   = brick_pkg::PADDLE_Y,
    parameter int LEFT_WALL  = brick_pkg::LEFT_WALL,
    parameter int RIGHT_WALL = brick_pkg::RIGHT_WALL,
    parameter int TOP_WALL   = brick_pkg::TOP_WALL
)
(
    input  logic       i_step,
    input  logic       i_brick,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic [8:0] i_paddle_x,
    input  logic       i_dir_x,
    input  logic       i_dir_y,
    output logic       o_dir_x,
    output logic       o_dir_y
);

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_px;
    logic        w_paddle_hit;

    assign w_x  = {1'b0, i_x};
    assign w_y  = {1'b0, i_y};
    assign w_px = {2'b00, i_paddle_x};

    assign w_paddle_hit = i_dir_y
        && (w_y + 11'(BALL_SIZE) == 11'(PADDLE_Y))
        && (w_x + 11'(BALL_SIZE) > w_px)
        && (w_x < w_px + 11'(PADDLE_W));

`ifdef BALL_CTRL_ENGLISH_EN
    logic [10:0] w_cx;
    assign w_cx = w_x + 11'(BALL_SIZE / 2);
`endif

    always_comb begin
        o_dir_x = i_dir_x;
        o_dir_y = i_dir_y;
        if (i_step) begin
            if (w_x <= 11'(LEFT_WALL) && !i_dir_x)
                o_dir_x = 1'b1;
            if (w_x + 11'(BALL_SIZE) >= 11'(RIGHT_WALL) && i_dir_x)
                o_dir_x = 1'b0;
            if (w_y <= 11'(TOP_WALL) && !i_dir_y)
                o_dir_y = 1'b1;
            if (w_paddle_hit) begin
                o_dir_y = 1'b0;
`ifdef BALL_CTRL_ENGLISH_EN
                if (w_cx < w_px + 11'(PADDLE_W / 3))
                    o_dir_x = 1'b0;
                else if (w_cx >= w_px + 11'(2 * PADDLE_W / 3))
                    o_dir_x = 1'b1;
`endif
            end
        end
        // brick pulse flips last so it wins over the wall/paddle result
        if (i_brick)
            o_dir_y = !o_dir_y;
    end

endmodule

// File: rtl/ball_ctrl.sv
// Ball position, serve/play/over FSM and lives counter.
// Optional paddle english: define BALL_CTRL_ENGLISH_EN.
module ball_ctrl
#(
    parameter int BALL_SIZE  = brick_pkg::BALL_SIZE,
    parameter int PADDLE_W   = brick_pkg::PADDLE_W,
    parameter int PADDLE_Y   = brick_pkg::PADDLE_Y,
    parameter int LEFT_WALL  = brick_pkg::LEFT_WALL,
    parameter int RIGHT_WALL = brick_pkg::RIGHT_WALL,
    parameter int TOP_WALL   = brick_pkg::TOP_WALL,
    parameter int BOTTOM_Y   = brick_pkg::BOTTOM_Y,
    parameter int LIVES      = brick_pkg::LIVES
)
(
    input  logic        clk,
    input  logic        rst,
    ball_ctrl_if.slave  bus
);

    import brick_pkg::*;

    localparam logic [9:0] X_OFS = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0] RST_X = 10'(290) + X_OFS;
    localparam logic [9:0] SRV_Y = 10'(PADDLE_Y - BALL_SIZE);

    game_state_t r_state;
    game_state_t w_state_nx;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [9:0]  w_x_nx;
    logic [9:0]  w_y_nx;
    logic [9:0]  w_x_mv;
    logic [9:0]  w_y_mv;
    logic        r_dx;
    logic        r_dy;
    logic        w_dx_nx;
    logic        w_dy_nx;
    logic        w_dx_col;
    logic        w_dy_col;
    logic [1:0]  r_lives;
    logic [1:0]  w_lives_nx;
    logic        r_miss;
    logic        w_miss_nx;

    ball_collide #(
        .BALL_SIZE  (BALL_SIZE),
        .PADDLE_W   (PADDLE_W),
        .PADDLE_Y   (PADDLE_Y),
        .LEFT_WALL  (LEFT_WALL),
        .RIGHT_WALL (RIGHT_WALL),
        .TOP_WALL   (TOP_WALL)
    ) u_collide (
        .i_step     (bus.tick),
        .i_brick    (bus.brick_hit),
        .i_x        (r_x),
        .i_y        (r_y),
        .i_paddle_x (bus.paddle_x),
        .i_dir_x    (r_dx),
        .i_dir_y    (r_dy),
        .o_dir_x    (w_dx_col),
        .o_dir_y    (w_dy_col)
    );

    assign w_x_mv = w_dx_col ? r_x + 10'd1 : r_x - 10'd1;
    assign w_y_mv = w_dy_col ? r_y + 10'd1 : r_y - 10'd1;

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_dx_nx    = r_dx;
        w_dy_nx    = r_dy;
        w_lives_nx = r_lives;
        w_miss_nx  = 1'b0;
        unique case (r_state)
            SERVE: begin
                w_x_nx = {1'b0, bus.paddle_x} + X_OFS;
                w_y_nx = SRV_Y;
                if (!bus.start) begin
                    w_state_nx = PLAY;
                    w_dx_nx    = 1'b1;
                    w_dy_nx    = 1'b0;
                end
            end
            PLAY: begin
                w_dx_nx = w_dx_col;
                w_dy_nx = w_dy_col;
                if (bus.tick) begin
                    w_x_nx = w_x_mv;
                    w_y_nx = w_y_mv;
                    if ({1'b0, w_y_mv} + 11'(BALL_SIZE)
                        >= 11'(BOTTOM_Y)) begin
                        w_miss_nx  = 1'b1;
                        w_lives_nx = r_lives - 2'd1;
                        w_state_nx = (r_lives == 2'd1) ? OVER : SERVE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SERVE;
            r_x     <= RST_X;
            r_y     <= SRV_Y;
            r_dx    <= 1'b1;
            r_dy    <= 1'b0;
            r_lives <= 2'(LIVES);
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_dx    <= w_dx_nx;
            r_dy    <= w_dy_nx;
            r_lives <= w_lives_nx;
            r_miss  <= w_miss_nx;
        end
    end

    assign bus.ball_x    = r_x;
    assign bus.ball_y    = r_y;
    assign bus.dir_x     = r_dx;
    assign bus.dir_y     = r_dy;
    assign bus.lives     = r_lives;
    assign bus.miss      = r_miss;
    assign bus.game_over = (r_state == OVER);

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: reference model feeds an expected-value
// queue, popped and compared after every clock edge.
module tb_ball_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ball_ctrl_if bus();

    ball_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
        logic [1:0] lives;
        logic       miss;
        logic       over;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // reference model state: 0 serve, 1 play, 2 over
    int m_state;
    int m_x;
    int m_y;
    int m_lives;
    bit m_dx;
    bit m_dy;
    bit m_miss;

    int misses = 0;
    bit did_corner = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_step(bit r, bit t, bit s_n, int px, bit b);
        bit ndx;
        bit ndy;
        int cx;
        if (r) begin
            m_state = 0; m_lives = 3; m_dx = 1; m_dy = 0;
            m_miss = 0; m_x = 317; m_y = 432;
            return;
        end
        m_miss = 0;
        if (m_state == 0) begin
            m_x = px + 27;
            m_y = 432;
            if (!s_n) begin
                m_state = 1; m_dx = 1; m_dy = 0;
            end
        end else if (m_state == 1) begin
            if (t) begin
                ndx = m_dx;
                ndy = m_dy;
                cx  = m_x + 4;
                if (m_x <= 134 && !m_dx) ndx = 1;
                if (m_x + 8 >= 506 && m_dx) ndx = 0;
                if (m_y <= 40 && !m_dy) ndy = 1;
                if (m_dy && m_y + 8 == 440 && m_x + 8 > px && m_x < px + 62) begin
                    ndy = 0;
`ifdef BALL_CTRL_ENGLISH_EN
                    if (cx < px + 20) ndx = 0;
                    else if (cx >= px + 41) ndx = 1;
`endif
                end
                if (b) ndy = !ndy;
                m_dx = ndx;
                m_dy = ndy;
                m_x = ndx ? m_x + 1 : m_x - 1;
                m_y = ndy ? m_y + 1 : m_y - 1;
                if (m_y + 8 >= 480) begin
                    m_miss = 1;
                    m_lives = m_lives - 1;
                    m_state = (m_lives == 0) ? 2 : 0;
                end
            end else if (b) begin
                m_dy = !m_dy;
            end
        end
    endtask

    task automatic step(bit r, bit t, bit s_n, int px, bit b);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.tick      = t;
        bus.start     = s_n;
        bus.paddle_x  = 9'(px);
        bus.brick_hit = b;
        model_step(r, t, s_n, px, b);
        e.x     = 10'(m_x);
        e.y     = 10'(m_y);
        e.dx    = m_dx;
        e.dy    = m_dy;
        e.lives = 2'(m_lives);
        e.miss  = m_miss;
        e.over  = (m_state == 2);
        q.push_back(e);
        @(posedge clk);
        #1;
        check("sb_avail", 32'(q.size()), 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check("ball_x", 32'(bus.ball_x), 32'(e.x));
            check("ball_y", 32'(bus.ball_y), 32'(e.y));
            check("dir_x", 32'(bus.dir_x), 32'(e.dx));
            check("dir_y", 32'(bus.dir_y), 32'(e.dy));
            check("lives", 32'(bus.lives), 32'(e.lives));
            check("miss", 32'(bus.miss), 32'(e.miss));
            check("game_over", 32'(bus.game_over), 32'(e.over));
        end
    endtask

    task automatic play(int keep_cyc, bit bricks);
        bit t, b, seen, dx0, dy0;
        int px, x0, y0, st0;
        seen = 0;
        for (int cyc = 0; cyc < 8000 && !seen; cyc++) begin
            t = (cyc % 2) == 0;
            if (cyc < keep_cyc) px = m_x - 27;
            else px = (m_x < 300) ? 440 : 0;
            b = 0;
            if (bricks && !t && m_y > 100 && m_y < 400
                && $urandom_range(0, 31) == 0)
                b = 1;
            if (bricks && t && !did_corner && m_y == 40 && !m_dy) begin
                b = 1;
                did_corner = 1;
            end
            x0 = m_x; y0 = m_y; dx0 = m_dx; dy0 = m_dy; st0 = m_state;
            step(0, t, 1, px, b);
            if (st0 == 1 && t) begin
                if (x0 == 498 && dx0) begin
                    check("rwall_dx", 32'(bus.dir_x), 0);
                    check("rwall_x", 32'(bus.ball_x), 497);
                end
                if (x0 == 134 && !dx0) begin
                    check("lwall_dx", 32'(bus.dir_x), 1);
                    check("lwall_x", 32'(bus.ball_x), 135);
                end
                if (y0 == 40 && !dy0 && !b) begin
                    check("top_dy", 32'(bus.dir_y), 1);
                    check("top_y", 32'(bus.ball_y), 41);
                end
                if (y0 == 432 && dy0 && !b) begin
                    if (cyc < keep_cyc) begin
                        check("pad_hit_dy", 32'(bus.dir_y), 0);
                        check("pad_hit_y", 32'(bus.ball_y), 431);
                    end else begin
                        check("pad_miss_dy", 32'(bus.dir_y), 1);
                        check("pad_miss_y", 32'(bus.ball_y), 433);
                    end
                end
            end
            if (m_miss) begin
                seen = 1;
                misses++;
                check("miss_lives", 32'(bus.lives), 32'(3 - misses));
            end
        end
        check("miss_seen", 32'(seen), 1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.tick      = 1'b0;
        bus.start     = 1'b1;
        bus.paddle_x  = 9'd290;
        bus.brick_hit = 1'b0;

        step(1, 0, 1, 290, 0);
        step(1, 0, 1, 290, 0);
        check("rst_x", 32'(bus.ball_x), 317);
        check("rst_y", 32'(bus.ball_y), 432);
        check("rst_lives", 32'(bus.lives), 3);
        check("rst_over", 32'(bus.game_over), 0);
        check("rst_dx", 32'(bus.dir_x), 1);

        step(0, 0, 1, 300, 0);
        check("snap_x", 32'(bus.ball_x), 327);
        step(0, 1, 1, 290, 1);
        step(0, 0, 0, 290, 0);
        step(0, 1, 1, 290, 0);
        check("play_x", 32'(bus.ball_x), 318);
        check("play_y", 32'(bus.ball_y), 431);

        step(0, 0, 1, 290, 1);
        check("brick_dy", 32'(bus.dir_y), 1);
        check("brick_x", 32'(bus.ball_x), 318);
        check("brick_y", 32'(bus.ball_y), 431);

        play(3000, 1);
        step(0, 0, 1, 250, 0);
        step(0, 0, 0, 250, 0);
        play(0, 0);
        step(0, 0, 1, 350, 0);
        step(0, 0, 0, 350, 0);
        play(0, 0);
        check("over_flag", 32'(bus.game_over), 1);
        check("over_lives", 32'(bus.lives), 0);

        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 290, i[0]);

        step(1, 0, 1, 290, 0);
        check("rerst_lives", 32'(bus.lives), 3);
        check("rerst_over", 32'(bus.game_over), 0);
        check("rerst_x", 32'(bus.ball_x), 317);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
